// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, instruction field positions and
// the fetch-stage state type.
package cpu_pkg;

    localparam logic [4:0] OP_MOV      = 5'b00001;
    localparam logic [4:0] OP_ADD      = 5'b00010;
    localparam logic [4:0] OP_MUL      = 5'b00100;
    localparam logic [4:0] OP_STOREREG = 5'b01101;
    localparam logic [4:0] OP_SENDDOUT = 5'b01111;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 27;
    localparam int RDST_MSB  = 26;
    localparam int RDST_LSB  = 22;
    localparam int RSRC1_MSB = 21;
    localparam int RSRC1_LSB = 17;
    localparam int IMM_BIT   = 16;
    localparam int ISRC_MSB  = 15;
    localparam int ISRC_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with flush. A push is accepted
// on a full queue when a pop happens on the same edge.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter int  W     = 36,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [W-1:0]  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (sys_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction supply stage: program memory, sequential prefetch into a small
// queue, valid/ready delivery to the core, and PC redirect.
module inst_fetch_queue
    import cpu_pkg::*;
#(
    parameter int IW     = 32,
    parameter int AW     = 4,
    parameter int QDEPTH = 4
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [IW-1:0] ld_data,
    input  logic          start,
    input  logic [AW-1:0] last_pc,
    input  logic          redirect_en,
    input  logic [AW-1:0] redirect_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [IW-1:0] inst_data,
    output logic [AW-1:0] inst_pc,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e     r_state;
    logic [IW-1:0]    r_mem [2**AW];
    logic [AW-1:0]    r_fpc;
    logic [AW-1:0]    r_last;
    logic             r_rd_vld;
    logic [AW-1:0]    r_rd_pc;
    logic [IW-1:0]    r_rd_data;

    logic [IW+AW-1:0] w_head;
    logic [CW-1:0]    w_count;
    logic [CW:0]      w_occ;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_redir;
    logic             w_issue;
    logic             w_drain_ok;

    fetch_fifo #(
        .DEPTH (QDEPTH),
        .W     (IW + AW)
    ) u_fifo (
        .clk     (clk),
        .sys_rst (sys_rst),
        .i_push  (r_rd_vld),
        .i_data  ({r_rd_pc, r_rd_data}),
        .i_pop   (w_pop),
        .i_flush (w_redir),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign inst_valid = !w_empty;
    assign inst_data  = inst_valid ? w_head[IW-1:0]  : '0;
    assign inst_pc    = inst_valid ? w_head[IW +: AW] : '0;
    assign busy       = (r_state == FETCH) || (r_state == DRAIN);
    assign done       = (r_state == DONE);

    assign w_pop   = inst_valid && inst_ready;
    assign w_redir = redirect_en && busy;

    // Slots already claimed by queued and in-flight words, net of this edge's pop,
    // so a read can be issued every cycle while the core keeps up.
    assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_rd_vld} - {{CW{1'b0}}, w_pop};
    assign w_issue = (r_state == FETCH) && !w_redir && (!w_full || w_pop)
                     && (w_occ < (CW+1)'(QDEPTH));

    assign w_drain_ok = !r_rd_vld && ((w_count == '0) || ((w_count == CW'(1)) && w_pop));

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state  <= IDLE;
            r_fpc    <= '0;
            r_last   <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_redir) begin
                r_state <= FETCH;
                r_fpc   <= redirect_pc;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (start) begin
                            r_state <= FETCH;
                            r_last  <= last_pc;
                            r_fpc   <= '0;
                        end
                    end
                    FETCH: begin
                        if (w_issue) begin
                            r_fpc <= r_fpc + 1'b1;
                            if (r_fpc == r_last) r_state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (w_drain_ok) r_state <= DONE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_rd_data <= r_mem[r_fpc];
            r_rd_pc   <= r_fpc;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_en && (r_state == IDLE)) r_mem[ld_addr] <= ld_data;
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed runs with literal expectations plus a
// per-cycle compare against a program-order model of the fetch stage.
module tb_inst_fetch_queue;

    localparam int IW = 32;
    localparam int AW = 4;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [IW-1:0] ld_data;
    logic          start;
    logic [AW-1:0] last_pc;
    logic          redirect_en;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [IW-1:0] inst_data;
    logic [AW-1:0] inst_pc;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    inst_fetch_queue #(.IW(IW), .AW(AW), .QDEPTH(QD)) dut (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .start       (start),
        .last_pc     (last_pc),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .busy        (busy),
        .done        (done)
    );

    int          n_vec  = 0;
    int          n_err  = 0;
    bit          mon_on = 1'b0;
    logic [31:0] prog_ref [16];

    // Model: run state (0 idle, 1 running, 2 done), next pc owed to the core,
    // final pc of the run, and the program memory as the core should see it.
    int          m_st   = 0;
    logic [3:0]  m_exp  = '0;
    logic [3:0]  m_last = '0;
    logic [31:0] m_mem [16];
    bit          m_hold = 1'b0;
    logic [3:0]  h_pc   = '0;
    logic [31:0] h_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic collect(input string tag, input logic [3:0] pc0, input int n);
        logic [3:0] pc;
        pc = pc0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
            chk({tag, "_pc"}, 32'(inst_pc), 32'(pc));
            chk({tag, "_data"}, inst_data, prog_ref[pc]);
            pc = pc + 4'd1;
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k;
        k = 0;
        while (!inst_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_wait_valid"}, 32'(inst_valid), 32'd1);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_valid_off"}, 32'(inst_valid), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("mon_busy", 32'(busy), 32'(m_st == 1));
            chk("mon_done", 32'(done), 32'(m_st == 2));
            if (!inst_valid) begin
                chk("mon_idle_data", inst_data, 32'h0);
                chk("mon_idle_pc", 32'(inst_pc), 32'h0);
            end else begin
                chk("mon_head_pc", 32'(inst_pc), 32'(m_exp));
                chk("mon_head_data", inst_data, m_mem[inst_pc]);
                if (m_hold) begin
                    chk("mon_stable_pc", 32'(inst_pc), 32'(h_pc));
                    chk("mon_stable_data", inst_data, h_data);
                end
            end
            if (m_st != 1) chk("mon_no_valid", 32'(inst_valid), 32'h0);
        end
        m_hold = inst_valid && !inst_ready && !sys_rst && !((m_st == 1) && redirect_en);
        h_pc   = inst_pc;
        h_data = inst_data;
        if (sys_rst) begin
            m_st = 0;
        end else begin
            if (ld_en && m_st == 0) m_mem[ld_addr] = ld_data;
            if (m_st == 1 && redirect_en) begin
                m_exp = redirect_pc;
            end else if (m_st == 1 && inst_valid && inst_ready) begin
                if (m_exp == m_last) m_st = 2;
                m_exp = m_exp + 4'd1;
            end else if (m_st != 1 && start) begin
                m_st   = 1;
                m_exp  = '0;
                m_last = last_pc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sys_rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; last_pc = '0; redirect_en = 1'b0; redirect_pc = '0;
        inst_ready = 1'b0;
        prog_ref = '{32'h08400005, 32'h08800003, 32'h10C40800, 32'h68060002,
                     32'h78000002, 32'h00000000, 32'h0A000006, 32'h0A000007,
                     32'h0A000008, 32'h0A000009, 32'h0A00000A, 32'h0A00000B,
                     32'h0A00000C, 32'h0A00000D, 32'h0A00000E, 32'h0A00000F};
        tick(2);
        mon_on = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", inst_data, 32'd0);
        chk("rst_pc", 32'(inst_pc), 32'd0);

        tick(1);
        sys_rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ld_en = 1'b1; ld_addr = 4'(i); ld_data = prog_ref[i];
            tick(1);
        end
        ld_en = 1'b0;

        // Run at full rate from pc 0 to 5.
        inst_ready = 1'b1; last_pc = 4'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        @(negedge clk); chk("t1_lat1", 32'(inst_valid), 32'd0);
        @(negedge clk); chk("t1_lat2", 32'(inst_valid), 32'd0);
        @(negedge clk); chk("t1_first_data", inst_data, 32'h08400005);
        collect("t1", 4'd0, 6);
        @(negedge clk); chk_done("t1");

        // Core stalled: head held, queue fills to depth, then drains in order.
        tick(1);
        inst_ready = 1'b0; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(10);
        @(negedge clk);
        chk("t2_hold_valid", 32'(inst_valid), 32'd1);
        chk("t2_hold_pc", 32'(inst_pc), 32'd0);
        chk("t2_hold_data", inst_data, 32'h08400005);
        chk("t2_depth", 32'(dut.w_count), 32'd4);
        tick(1);
        inst_ready = 1'b1;
        @(negedge clk); collect("t2", 4'd0, 6);
        @(negedge clk); chk_done("t2");

        // Redirect to 1 while pc 3 is being taken.
        tick(1);
        start = 1'b1; last_pc = 4'd5;
        tick(1);
        start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        collect("t3a", 4'd0, 3);
        tick(1);
        redirect_en = 1'b1; redirect_pc = 4'd1;
        @(negedge clk); chk("t3_head_pc", 32'(inst_pc), 32'd3);
        tick(1);
        redirect_en = 1'b0;
        @(negedge clk); chk("t3_flush", 32'(inst_valid), 32'd0);
        wait_valid("t3", 8);
        collect("t3b", 4'd1, 5);
        @(negedge clk); chk_done("t3");

        // Redirect to 14 with last_pc 1: fetch address wraps.
        tick(1);
        last_pc = 4'd1; start = 1'b1;
        tick(1);
        start = 1'b0; redirect_en = 1'b1; redirect_pc = 4'd14;
        tick(1);
        redirect_en = 1'b0;
        @(negedge clk); wait_valid("t4", 8);
        chk("t4_first_data", inst_data, 32'h0A00000E);
        collect("t4", 4'd14, 4);
        @(negedge clk); chk_done("t4");

        // Reset with three entries queued, then replay from pc 0.
        tick(1);
        inst_ready = 1'b0; last_pc = 4'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        sys_rst = 1'b1;
        @(negedge clk); chk("t5_queued", 32'(dut.w_count), 32'd3);
        tick(1);
        sys_rst = 1'b0;
        @(negedge clk);
        chk("t5_valid", 32'(inst_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_pc", 32'(inst_pc), 32'd0);
        tick(1);
        inst_ready = 1'b1; start = 1'b1;
        tick(1);
        start = 1'b0;
        @(negedge clk); chk("t5_lat1", 32'(inst_valid), 32'd0);
        @(negedge clk); chk("t5_lat2", 32'(inst_valid), 32'd0);
        @(negedge clk); collect("t5", 4'd0, 6);
        @(negedge clk); chk_done("t5");

        // Load during a run is dropped.
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0; ld_en = 1'b1; ld_addr = 4'd2; ld_data = 32'hFFFFFFFF;
        tick(1);
        ld_en = 1'b0;
        @(negedge clk); wait_valid("t6a", 8);
        collect("t6a", 4'd0, 6);
        @(negedge clk); chk_done("t6a");

        // Loads in IDLE land, including one on the same edge as start.
        tick(1);
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0; ld_en = 1'b1; ld_addr = 4'd2; ld_data = 32'hFFFFFFFF;
        tick(1);
        ld_addr = 4'd0; ld_data = 32'h08400007; start = 1'b1; last_pc = 4'd5;
        tick(1);
        ld_en = 1'b0; start = 1'b0;
        prog_ref[0] = 32'h08400007;
        prog_ref[2] = 32'hFFFFFFFF;
        @(negedge clk); @(negedge clk);
        @(negedge clk); chk("t6b_first_data", inst_data, 32'h08400007);
        collect("t6b", 4'd0, 6);
        @(negedge clk); chk_done("t6b");

        tick(1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
